// File: rtl/ether_tx.sv
// RMII transmit framer: one 32-bit payload word per frame, serialized two bits per clock
// with preamble/SFD, MAC header, EtherType, payload, reflected CRC-32 FCS and an inter-frame gap.
module ether_tx #(
    parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC   = 48'h69_69_69_69_69_69,
    parameter logic [15:0] ETHERTYPE = 16'h6969
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [31:0] axiid,
    output logic        busy,
    output logic        txen,
    output logic [1:0]  txd
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DST,
        SRC,
        ETYPE,
        DATA,
        FCS,
        GAP
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [31:0] data_reg, data_next;
    logic [31:0] crc_reg, crc_next;
    logic        txen_reg, txen_next;
    logic [1:0]  txd_reg, txd_next;

    // Field is left-aligned in 48 bits; bytes go out MSB-first, bits within a byte LSB-first.
    function automatic logic [1:0] field_dibit(input logic [47:0] field, input logic [4:0] idx);
        logic [47:0] shifted;
        logic [7:0]  byte_sel;
        shifted  = field << {idx[4:2], 3'b000};
        byte_sel = shifted[47:40] >> {idx[1:0], 1'b0};
        return byte_sel[1:0];
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [1:0] dibit);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ ((r[0] ^ dibit[i]) ? 32'hEDB8_8320 : 32'h0000_0000);
        end
        return r;
    endfunction

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 6'd1;
        data_next  = data_reg;
        crc_next   = crc_reg;
        txen_next  = 1'b0;
        txd_next   = 2'b00;

        case (state_reg)
            IDLE: begin
                cnt_next = 6'd0;
                if (axiiv) begin
                    state_next = PREAMBLE;
                    data_next  = axiid;
                    crc_next   = 32'hFFFF_FFFF;
                end
            end
            PREAMBLE: if (cnt_reg == 6'd31) begin state_next = DST;   cnt_next = 6'd0; end
            DST:      if (cnt_reg == 6'd23) begin state_next = SRC;   cnt_next = 6'd0; end
            SRC:      if (cnt_reg == 6'd23) begin state_next = ETYPE; cnt_next = 6'd0; end
            ETYPE:    if (cnt_reg == 6'd7)  begin state_next = DATA;  cnt_next = 6'd0; end
            DATA:     if (cnt_reg == 6'd15) begin state_next = FCS;   cnt_next = 6'd0; end
            FCS:      if (cnt_reg == 6'd15) begin state_next = GAP;   cnt_next = 6'd0; end
            GAP:      if (cnt_reg == 6'd46) begin state_next = IDLE;  cnt_next = 6'd0; end
            default: begin
                state_next = IDLE;
                cnt_next   = 6'd0;
            end
        endcase

        // Outputs are registered, so the dibit for the upcoming state/count is chosen here.
        case (state_next)
            PREAMBLE: begin
                txen_next = 1'b1;
                txd_next  = (cnt_next == 6'd31) ? 2'b11 : 2'b01;
            end
            DST: begin
                txen_next = 1'b1;
                txd_next  = field_dibit(DST_MAC, cnt_next[4:0]);
                crc_next  = crc_step(crc_reg, txd_next);
            end
            SRC: begin
                txen_next = 1'b1;
                txd_next  = field_dibit(SRC_MAC, cnt_next[4:0]);
                crc_next  = crc_step(crc_reg, txd_next);
            end
            ETYPE: begin
                txen_next = 1'b1;
                txd_next  = field_dibit({ETHERTYPE, 32'h0000_0000}, cnt_next[4:0]);
                crc_next  = crc_step(crc_reg, txd_next);
            end
            DATA: begin
                txen_next = 1'b1;
                txd_next  = field_dibit({data_reg, 16'h0000}, cnt_next[4:0]);
                crc_next  = crc_step(crc_reg, txd_next);
            end
            FCS: begin
                // CRC register is frozen here; the count selects which complemented pair goes out.
                txen_next = 1'b1;
                txd_next  = ~crc_reg[{cnt_next[3:0], 1'b0} +: 2];
            end
            default: begin
                txen_next = 1'b0;
                txd_next  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 6'd0;
            data_reg  <= 32'h0000_0000;
            crc_reg   <= 32'h0000_0000;
            txen_reg  <= 1'b0;
            txd_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            crc_reg   <= crc_next;
            txen_reg  <= txen_next;
            txd_reg   <= txd_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign txen = txen_reg;
    assign txd  = txd_reg;

endmodule

// File: tb/tb_ether_tx.sv
// Self-checking bench for ether_tx: frames are rebuilt byte-by-byte from the header fields and
// payload, with a bit-serial reflected CRC-32, and compared dibit-for-dibit with the wire.
module tb_ether_tx;

    localparam logic [47:0] DST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC_MAC = 48'h69_69_69_69_69_69;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axiiv = 1'b0;
    logic        axiiv2 = 1'b0;
    logic [31:0] axiid = 32'h0;
    logic        busy, txen, busy2, txen2;
    logic [1:0]  txd, txd2;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_d [0:119];
    logic [1:0] got_d [0:255];
    int         got_len;

    always #10 clk = ~clk;

    ether_tx u_dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .busy(busy), .txen(txen), .txd(txd)
    );

    ether_tx #(.ETHERTYPE(16'h0800)) u_dut_et (
        .clk(clk), .rst(rst), .axiiv(axiiv2), .axiid(axiid),
        .busy(busy2), .txen(txen2), .txd(txd2)
    );

    function automatic logic [31:0] model_crc_bit(input logic [31:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return (crc >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
    endfunction

    // Expected 120-dibit frame from the field values.
    function automatic void build_frame(input logic [15:0] et, input logic [31:0] pl);
        logic [7:0]  bytes [0:17];
        logic [31:0] crc, fcs;
        logic [1:0]  dib;
        int n;
        for (int i = 0; i < 6; i++) bytes[i]      = DST_MAC[47 - 8*i -: 8];
        for (int i = 0; i < 6; i++) bytes[6 + i]  = SRC_MAC[47 - 8*i -: 8];
        bytes[12] = et[15:8];
        bytes[13] = et[7:0];
        for (int i = 0; i < 4; i++) bytes[14 + i] = pl[31 - 8*i -: 8];
        for (int i = 0; i < 31; i++) exp_d[i] = 2'b01;
        exp_d[31] = 2'b11;
        n = 32;
        crc = 32'hFFFF_FFFF;
        for (int b = 0; b < 18; b++) begin
            for (int k = 0; k < 4; k++) begin
                dib = {bytes[b][2*k+1], bytes[b][2*k]};
                exp_d[n] = dib;
                n++;
                crc = model_crc_bit(crc, dib[0]);
                crc = model_crc_bit(crc, dib[1]);
            end
        end
        fcs = ~crc;
        for (int k = 0; k < 16; k++) begin
            exp_d[n] = {fcs[2*k+1], fcs[2*k]};
            n++;
        end
    endfunction

    function automatic logic [31:0] got_residue(input int start);
        logic [31:0] crc;
        crc = 32'hFFFF_FFFF;
        for (int i = start + 32; i < start + 120; i++) begin
            crc = model_crc_bit(crc, got_d[i][0]);
            crc = model_crc_bit(crc, got_d[i][1]);
        end
        return crc;
    endfunction

    // Waits for txen, records the frame, then follows busy to the end of the gap.
    task automatic collect(input bit sel, output int wait_cyc, output int busy_cyc);
        logic en, bz;
        wait_cyc = 0;
        busy_cyc = 0;
        got_len  = 0;
        en = 1'b0;
        bz = 1'b0;
        while (!en && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
            en = sel ? txen2 : txen;
        end
        axiiv  = 1'b0;
        axiiv2 = 1'b0;
        if (!en) begin
            checks++; errors++;
            $display("FAIL collect_start txen=0 expected 1 within 10 cycles");
            return;
        end
        while (en && got_len < 200) begin
            got_d[got_len] = sel ? txd2 : txd;
            got_len++;
            bz = sel ? busy2 : busy;
            if (bz) busy_cyc++;
            axiid = $urandom;
            @(negedge clk);
            en = sel ? txen2 : txen;
        end
        bz = sel ? busy2 : busy;
        while (bz && busy_cyc < 400) begin
            busy_cyc++;
            @(negedge clk);
            bz = sel ? busy2 : busy;
        end
    endtask

    task automatic test_reset();
        int w, b, bad;
        logic [31:0] word;
        @(negedge clk);
        rst = 1'b1;
        axiiv = 1'b1;
        word = $urandom;
        axiid = word;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (txen !== 1'b0 || txd !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got txen=%b txd=%b busy=%b expected 0 00 0", i, txen, txd, busy);
            end
        end
        rst = 1'b0;
        build_frame(16'h6969, word);
        collect(1'b0, w, b);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL reset_first_accept got wait=%0d expected 1", w);
        end
        bad = 0;
        for (int i = 0; i < 120; i++) if (got_d[i] !== exp_d[i]) bad++;
        checks++;
        if (got_len !== 120 || bad !== 0) begin
            errors++;
            $display("FAIL reset_frame got len=%0d bad=%0d expected len=120 bad=0", got_len, bad);
        end
        $display("reset: word=%h len=%0d wait=%0d", word, got_len, w);
    endtask

    task automatic test_single();
        int w, b, bad;
        logic [31:0] res;
        @(negedge clk);
        axiiv = 1'b1;
        axiid = 32'h1234_5678;
        build_frame(16'h6969, 32'h1234_5678);
        collect(1'b0, w, b);
        checks++;
        if (got_len !== 120) begin
            errors++;
            $display("FAIL single_len got %0d expected 120", got_len);
        end
        checks++;
        if (b !== 167) begin
            errors++;
            $display("FAIL single_busy got %0d expected 167", b);
        end
        checks++;
        if (got_d[30] !== 2'b01 || got_d[31] !== 2'b11 || got_d[32] !== 2'b11) begin
            errors++;
            $display("FAIL single_sfd got %b %b %b expected 01 11 11", got_d[30], got_d[31], got_d[32]);
        end
        checks++;
        if (got_d[56] !== 2'b01 || got_d[57] !== 2'b10 || got_d[58] !== 2'b10 || got_d[59] !== 2'b01) begin
            errors++;
            $display("FAIL single_src0 got %b %b %b %b expected 01 10 10 01", got_d[56], got_d[57], got_d[58], got_d[59]);
        end
        checks++;
        if (got_d[88] !== 2'b10 || got_d[89] !== 2'b00 || got_d[90] !== 2'b01 || got_d[91] !== 2'b00) begin
            errors++;
            $display("FAIL single_payload0 got %b %b %b %b expected 10 00 01 00", got_d[88], got_d[89], got_d[90], got_d[91]);
        end
        bad = 0;
        for (int i = 0; i < 120; i++) if (got_d[i] !== exp_d[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL single_frame got %0d wrong dibits expected 0", bad);
        end
        res = got_residue(0);
        checks++;
        if (res !== 32'hDEBB_20E3) begin
            errors++;
            $display("FAIL single_residue got %h expected debb20e3", res);
        end
        $display("single: word=12345678 len=%0d busy=%0d residue=%h", got_len, b, res);
    endtask

    task automatic test_random();
        int w, b, bad;
        logic [31:0] word, res;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            word = $urandom;
            axiiv = 1'b1;
            axiid = word;
            build_frame(16'h6969, word);
            collect(1'b0, w, b);
            bad = 0;
            for (int i = 0; i < 120; i++) if (got_d[i] !== exp_d[i]) bad++;
            res = got_residue(0);
            checks++;
            if (got_len !== 120 || bad !== 0 || res !== 32'hDEBB_20E3) begin
                errors++;
                $display("FAIL random_frame word=%h got len=%0d bad=%0d residue=%h expected 120 0 debb20e3", word, got_len, bad, res);
            end
            $display("random: word=%h len=%0d residue=%h", word, got_len, res);
        end
    endtask

    task automatic test_back_to_back();
        logic        rec_en [0:300];
        logic        rec_b  [0:300];
        logic [1:0]  rec_d  [0:300];
        logic [31:0] wa, wb, wc;
        int f, r, bcnt, bad, guard;
        wa = $urandom;
        wb = $urandom;
        wc = ~wa;
        @(negedge clk);
        axiiv = 1'b1;
        axiid = wa;
        rec_en[0] = 1'b0; rec_b[0] = 1'b0; rec_d[0] = 2'b00;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            rec_en[k] = txen;
            rec_b[k]  = busy;
            rec_d[k]  = txd;
            if (k == 1)  axiid = wc;
            if (k == 10) axiid = wb;
        end
        axiiv = 1'b0;
        guard = 0;
        while (busy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        f = 0;
        for (int k = 1; k <= 300; k++) if (f == 0 && rec_en[k] !== 1'b1) f = k;
        r = 0;
        for (int k = 1; k <= 300; k++) if (r == 0 && f != 0 && k > f && rec_en[k] === 1'b1) r = k;
        bcnt = 0;
        for (int k = 1; k <= 300; k++) if (bcnt == k - 1 && rec_b[k] === 1'b1) bcnt = k;
        checks++;
        if (f !== 121) begin
            errors++;
            $display("FAIL b2b_first_len got txen low at %0d expected 121", f);
        end
        checks++;
        if (r - f !== 48) begin
            errors++;
            $display("FAIL b2b_gap got %0d idle cycles expected 48", r - f);
        end
        checks++;
        if (bcnt !== 167) begin
            errors++;
            $display("FAIL b2b_busy got %0d expected 167", bcnt);
        end
        build_frame(16'h6969, wa);
        bad = 0;
        for (int i = 0; i < 120; i++) if (rec_d[i + 1] !== exp_d[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_frame_a got %0d wrong dibits expected 0", bad);
        end
        build_frame(16'h6969, wb);
        bad = 0;
        if (r < 1 || r + 120 > 300) bad = 999;
        else for (int i = 0; i < 120; i++) if (rec_d[r + i] !== exp_d[i] || rec_en[r + i] !== 1'b1) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_frame_b got %0d wrong dibits expected 0", bad);
        end
        $display("back_to_back: a=%h b=%h pulsed=%h gap=%0d busy=%0d", wa, wb, wc, r - f, bcnt);
    endtask

    task automatic test_mid_reset();
        int w, b, bad;
        logic [31:0] w1, w2, res;
        w1 = $urandom;
        w2 = $urandom;
        @(negedge clk);
        axiiv = 1'b1;
        axiid = w1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) axiiv = 1'b0;
        end
        checks++;
        if (txen !== 1'b1) begin
            errors++;
            $display("FAIL midrst_inflight got txen=%b expected 1", txen);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txen !== 1'b0 || busy !== 1'b0 || txd !== 2'b00) begin
            errors++;
            $display("FAIL midrst_abort got txen=%b busy=%b txd=%b expected 0 0 00", txen, busy, txd);
        end
        rst = 1'b0;
        axiiv = 1'b1;
        axiid = w2;
        build_frame(16'h6969, w2);
        collect(1'b0, w, b);
        bad = 0;
        for (int i = 0; i < 120; i++) if (got_d[i] !== exp_d[i]) bad++;
        res = got_residue(0);
        checks++;
        if (w !== 1 || got_len !== 120 || bad !== 0 || res !== 32'hDEBB_20E3) begin
            errors++;
            $display("FAIL midrst_restart got wait=%0d len=%0d bad=%0d residue=%h expected 1 120 0 debb20e3", w, got_len, bad, res);
        end
        $display("mid_reset: aborted=%h restart=%h len=%0d residue=%h", w1, w2, got_len, res);
    endtask

    task automatic test_ethertype();
        logic [1:0] et_exp [0:7];
        int w, b, bad;
        logic [31:0] word, res;
        et_exp = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        word = $urandom;
        @(negedge clk);
        axiiv2 = 1'b1;
        axiid = word;
        build_frame(16'h0800, word);
        collect(1'b1, w, b);
        bad = 0;
        for (int i = 0; i < 8; i++) if (got_d[80 + i] !== et_exp[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ethertype_field got %0d wrong dibits expected 0", bad);
        end
        bad = 0;
        for (int i = 0; i < 120; i++) if (got_d[i] !== exp_d[i]) bad++;
        res = got_residue(0);
        checks++;
        if (got_len !== 120 || bad !== 0 || res !== 32'hDEBB_20E3) begin
            errors++;
            $display("FAIL ethertype_frame got len=%0d bad=%0d residue=%h expected 120 0 debb20e3", got_len, bad, res);
        end
        $display("ethertype0800: word=%h len=%0d residue=%h", word, got_len, res);
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_ethertype();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
